gray_converter_arbiter: RTL and testbench
=========================================

# gray_converter_arbiter

Round-robin arbiter and sequencer that shares one 4-bit binary-to-Gray converter among up to 8 requesters. It accepts one request at a time over a valid/ready handshake and drives the shared converter for exactly one cycle. The result is registered and returned, tagged with the requester ID, over a second valid/ready handshake. The block sits between client blocks that need occasional Gray encoding (pointer synchronisers, position encoders) and the single converter instance it owns.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- Clock_In  in  1  single clock, rising edge
- Reset_N_In  in  1  asynchronous, active-low reset
- Req_Valid_In  in  NUM_REQ  per-requester request valid
- Req_Data_In  in  4*NUM_REQ  binary operand; requester i uses bits [4i+3:4i]
- Req_Ready_Out  out  NUM_REQ  one-hot accept strobe; all zero when no grant
- Rsp_Valid_Out  out  1  response valid
- Rsp_Id_Out  out  3  index of the requester that owns the response
- Rsp_Data_Out  out  4  Gray-coded result
- Rsp_Ready_In  in  1  response consumer ready
- Busy_Out  out  1  high whenever state is not IDLE

## Operation
- The converter instance is owned internally. Its Enable_In is high only in CONVERT. Its tri-state output is sampled only in CONVERT, so Z never reaches a register.
- Three-state FSM: IDLE, CONVERT, HOLD.
- **IDLE:**
  - If any Req_Valid_In bit is set, the grant goes to the first set bit searching upward, with wrap, from Last_Grant+1.
  - Req_Ready_Out[grant] is asserted combinationally in the same cycle.
  - At the edge, the operand and ID are latched, Last_Grant is set to the grant, and the FSM goes to CONVERT.
  - If no bit is set, the FSM stays in IDLE and Req_Ready_Out is 0.
- **CONVERT:** one cycle. At the edge, the converter output is registered into Rsp_Data_Out, the latched ID goes to Rsp_Id_Out, Rsp_Valid_Out is set to 1, and the FSM goes to HOLD.
- **HOLD:**
  - Rsp_Valid_Out, Rsp_Id_Out and Rsp_Data_Out hold stable.
  - On an edge with Rsp_Ready_In=1, Rsp_Valid_Out is cleared and the FSM goes to IDLE.
  - Rsp_Data_Out and Rsp_Id_Out keep their last values after that edge.
- Requester rules:
  - Req_Valid_In and the operand must stay stable until Req_Ready_Out is seen.
  - Dropping valid before the grant is legal; that requester is simply not granted.
- Req_Ready_Out is 0 in CONVERT and HOLD. No new request is accepted until the response is consumed.
- Conversion: g[3]=b[3], g[i]=b[i]^b[i+1] for i=2..0.
- Rsp_Id_Out is zero-extended to 3 bits.

## Timing
- Reset (asynchronous assert; release synchronised by the system):
  - State IDLE; Last_Grant = NUM_REQ-1, so requester 0 has first priority.
  - Req_Ready_Out, Rsp_Valid_Out, Rsp_Id_Out, Rsp_Data_Out and Busy_Out are all 0.
- Latency:
  - Acceptance edge E0.
  - Rsp_Valid_Out is high from E1 (one edge later).
  - Earliest completion is E2 if Rsp_Ready_In=1 during HOLD.
  - Earliest next acceptance is E3, giving peak throughput of 1 result per 3 cycles.
- Simultaneous requests: only the round-robin winner sees ready; the others wait without loss.
- Wrap-around: after a grant to NUM_REQ-1, the search restarts at 0.
- Backpressure: indefinite Rsp_Ready_In=0 holds HOLD indefinitely with all outputs frozen.
- Rsp_Ready_In while Rsp_Valid_Out=0 is ignored.
- Reset mid-operation (CONVERT or HOLD): the in-flight request is discarded, no response is produced, and the reset values above apply.

## Test plan
- Single request: reset, then requester 0 valid with data 4'b1011.
  - Req_Ready_Out=4'b0001 for one cycle.
  - One edge later: Rsp_Valid_Out=1, Rsp_Id_Out=0, Rsp_Data_Out=4'b1110.
  - With Rsp_Ready_In=1 throughout, Busy_Out is high for exactly 2 cycles.
- Simultaneous requests: all four requesters valid after reset with data 0,1,2,3 and Rsp_Ready_In=1.
  - Grants in order 0,1,2,3, each 3 cycles apart.
  - Responses 0000, 0001, 0011, 0010 with matching IDs.
- Backpressure: Rsp_Ready_In=0 for 5 cycles in HOLD while requesters 1 and 2 are valid.
  - Response outputs are constant and Req_Ready_Out=0 throughout.
  - After Rsp_Ready_In rises, Rsp_Valid_Out drops and the next grant goes to the requester after the last one served.
- Fairness: requesters 0 and 2 continuously valid for 8 grants → grant sequence 0,2,0,2,0,2,0,2; requester 1 is never granted.
- Reset mid-operation: assert Reset_N_In=0 during CONVERT of requester 3 (data 4'b1111).
  - Immediately: all outputs 0 and no response.
  - After release with requesters 0 and 3 valid, requester 0 is granted first.
- Exhaustive: requester 3 issues operands 0..15 in sequence → each Rsp_Data_Out equals b^(b>>1) and each Rsp_Id_Out=3.

Source files
------------

// File: rtl/gray_converter_arbiter_if.sv
// Request/response bundle for the shared Gray converter arbiter.
// master = requesters and response consumer, slave = arbiter.
interface gray_converter_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   Req_Valid_In;
    logic [4*NUM_REQ-1:0] Req_Data_In;
    logic [NUM_REQ-1:0]   Req_Ready_Out;
    logic                 Rsp_Valid_Out;
    logic [2:0]           Rsp_Id_Out;
    logic [3:0]           Rsp_Data_Out;
    logic                 Rsp_Ready_In;
    logic                 Busy_Out;

    modport master (
        output Req_Valid_In,
        output Req_Data_In,
        output Rsp_Ready_In,
        input  Req_Ready_Out,
        input  Rsp_Valid_Out,
        input  Rsp_Id_Out,
        input  Rsp_Data_Out,
        input  Busy_Out
    );

    modport slave (
        input  Req_Valid_In,
        input  Req_Data_In,
        input  Rsp_Ready_In,
        output Req_Ready_Out,
        output Rsp_Valid_Out,
        output Rsp_Id_Out,
        output Rsp_Data_Out,
        output Busy_Out
    );
endinterface

// File: rtl/gray_converter_arbiter.sv
// Round-robin arbiter sharing one 4-bit binary-to-Gray converter
// among up to 8 requesters, with a registered tagged response.
module gray_conv (
    input  logic       Enable_In,
    input  logic [3:0] Bin_In,
    output wire  [3:0] Gray_Out
);
    assign Gray_Out = Enable_In
                    ? {Bin_In[3], Bin_In[3:1] ^ Bin_In[2:0]}
                    : 4'bz;
endmodule

module gray_converter_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                     Clock_In,
    input  logic                     Reset_N_In,
    gray_converter_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0] state;
    logic [2:0] last_grant;
    logic [2:0] grant;
    logic       found;
    logic [3:0] operand;
    logic [2:0] op_id;
    logic [3:0] sel_data;
    logic [7:0] valid8;
    logic [31:0] data32;
    logic [7:0] ready8;
    logic       conv_en;
    wire  [3:0] conv_gray;
    logic       rsp_valid;
    logic [2:0] rsp_id;
    logic [3:0] rsp_data;

    assign valid8   = 8'(bus.Req_Valid_In);
    assign data32   = 32'(bus.Req_Data_In);
    assign sel_data = data32[{grant, 2'b00} +: 4];
    assign ready8   = 8'b1 << grant;
    assign conv_en  = (state == CONVERT);

    gray_conv u_conv (
        .Enable_In (conv_en),
        .Bin_In    (operand),
        .Gray_Out  (conv_gray)
    );

    // Round-robin search upward from last_grant+1; nearest hit wins.
    always_comb begin
        logic [2:0] idx;
        idx   = '0;
        found = 1'b0;
        grant = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 3'((int'(last_grant) + k) % NUM_REQ);
            if (valid8[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign bus.Req_Ready_Out = (Reset_N_In && state == IDLE && found)
                             ? ready8[NUM_REQ-1:0] : '0;
    assign bus.Rsp_Valid_Out = rsp_valid;
    assign bus.Rsp_Id_Out    = rsp_id;
    assign bus.Rsp_Data_Out  = rsp_data;
    assign bus.Busy_Out      = (state != IDLE);

    // Accept, convert for one cycle, then hold the response until taken.
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state      <= IDLE;
            last_grant <= 3'(NUM_REQ - 1);
            operand    <= '0;
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        operand    <= sel_data;
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    rsp_data  <= conv_gray;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (bus.Rsp_Ready_In) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gray_converter_arbiter.sv
// Directed bench for gray_converter_arbiter.
// Hand-computed Gray results, one check task for every compare.
module tb_gray_converter_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   vecs = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    gray_converter_arbiter_if #(.NUM_REQ(4)) bus ();

    gray_converter_arbiter #(.NUM_REQ(4)) dut (
        .Clock_In   (clk),
        .Reset_N_In (rst_n),
        .bus        (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v,
                           input logic [3:0] d);
        bus.Req_Valid_In[id] = v;
        bus.Req_Data_In[4*id +: 4] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Req_Valid_In = '0;
        bus.Req_Data_In  = '0;
        bus.Rsp_Ready_In = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.Req_Ready_Out), 32'h0);
        check("rst_valid", 32'(bus.Rsp_Valid_Out), 32'h0);
        check("rst_id",    32'(bus.Rsp_Id_Out),    32'h0);
        check("rst_data",  32'(bus.Rsp_Data_Out),  32'h0);
        check("rst_busy",  32'(bus.Busy_Out),      32'h0);
        rst_n = 1'b1;
    endtask

    task automatic expect_grant(input int id, input logic [3:0] g,
                                input bit drop, output int waits);
        logic [3:0] want;
        want  = 4'b0001 << id;
        waits = 0;
        while (bus.Req_Ready_Out == '0 && waits < 12) begin
            @(negedge clk);
            waits++;
        end
        check("grant", 32'(bus.Req_Ready_Out), 32'(want));
        if (bus.Req_Ready_Out == '0) return;
        @(negedge clk);
        if (drop) bus.Req_Valid_In[id] = 1'b0;
        check("cvt_ready", 32'(bus.Req_Ready_Out), 32'h0);
        check("cvt_busy",  32'(bus.Busy_Out),      32'h1);
        @(negedge clk);
        check("rsp_valid", 32'(bus.Rsp_Valid_Out), 32'h1);
        check("rsp_id",    32'(bus.Rsp_Id_Out),    32'(id));
        check("rsp_data",  32'(bus.Rsp_Data_Out),  32'(g));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        logic [3:0] b;
        bus.Req_Valid_In = '0;
        bus.Req_Data_In  = '0;
        bus.Rsp_Ready_In = 1'b1;
        #1;

        // single request
        do_reset();
        set_req(0, 1'b1, 4'b1011);
        #1;
        check("s_ready", 32'(bus.Req_Ready_Out), 32'h1);
        check("s_busy0", 32'(bus.Busy_Out), 32'h0);
        @(negedge clk);
        bus.Req_Valid_In[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                check("s_valid", 32'(bus.Rsp_Valid_Out), 32'h1);
                check("s_id",    32'(bus.Rsp_Id_Out),    32'h0);
                check("s_data",  32'(bus.Rsp_Data_Out),  32'hE);
            end
            if (bus.Busy_Out) n++;
            @(negedge clk);
        end
        check("s_busy_cycles", 32'(n), 32'd2);

        // simultaneous requests
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i));
        #1;
        expect_grant(0, 4'b0000, 1'b1, w);
        expect_grant(1, 4'b0001, 1'b1, w);
        check("gap1", 32'(w), 32'd1);
        expect_grant(2, 4'b0011, 1'b1, w);
        check("gap2", 32'(w), 32'd1);
        expect_grant(3, 4'b0010, 1'b1, w);
        check("gap3", 32'(w), 32'd1);

        // backpressure
        do_reset();
        bus.Rsp_Ready_In = 1'b0;
        set_req(1, 1'b1, 4'd5);
        set_req(2, 1'b1, 4'd9);
        #1;
        check("bp_grant", 32'(bus.Req_Ready_Out), 32'h2);
        @(negedge clk);
        check("bp_cvt_ready", 32'(bus.Req_Ready_Out), 32'h0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.Rsp_Valid_Out), 32'h1);
            check("bp_id",    32'(bus.Rsp_Id_Out),    32'h1);
            check("bp_data",  32'(bus.Rsp_Data_Out),  32'h7);
            check("bp_ready", 32'(bus.Req_Ready_Out), 32'h0);
            @(negedge clk);
        end
        bus.Rsp_Ready_In = 1'b1;
        @(negedge clk);
        check("bp_drop",  32'(bus.Rsp_Valid_Out), 32'h0);
        check("bp_keepd", 32'(bus.Rsp_Data_Out),  32'h7);
        check("bp_keepi", 32'(bus.Rsp_Id_Out),    32'h1);
        bus.Req_Valid_In[1] = 1'b0;
        #1;
        expect_grant(2, 4'b1101, 1'b1, w);

        // fairness
        do_reset();
        set_req(0, 1'b1, 4'd3);
        set_req(2, 1'b1, 4'd6);
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) expect_grant(0, 4'b0010, 1'b0, w);
            else            expect_grant(2, 4'b0101, 1'b0, w);
        end
        bus.Req_Valid_In = '0;

        // reset mid-operation
        do_reset();
        set_req(3, 1'b1, 4'b1111);
        #1;
        check("mr_grant", 32'(bus.Req_Ready_Out), 32'h8);
        @(negedge clk);
        check("mr_busy", 32'(bus.Busy_Out), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mr_ready", 32'(bus.Req_Ready_Out), 32'h0);
        check("mr_valid", 32'(bus.Rsp_Valid_Out), 32'h0);
        check("mr_id",    32'(bus.Rsp_Id_Out),    32'h0);
        check("mr_data",  32'(bus.Rsp_Data_Out),  32'h0);
        check("mr_busy0", 32'(bus.Busy_Out),      32'h0);
        repeat (3) begin
            @(negedge clk);
            check("mr_norsp", 32'(bus.Rsp_Valid_Out), 32'h0);
        end
        set_req(0, 1'b1, 4'b0110);
        rst_n = 1'b1;
        #1;
        expect_grant(0, 4'b0101, 1'b1, w);
        expect_grant(3, 4'b1000, 1'b1, w);

        // exhaustive on requester 3
        for (int i = 0; i < 16; i++) begin
            b = 4'(i);
            set_req(3, 1'b1, b);
            #1;
            expect_grant(3, b ^ (b >> 1), 1'b1, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
